// File: rtl/scanner_link_arbiter.sv
// Round-robin arbiter that shares one serial link between two scanner units.
// Optional build macro LINK_PARITY_EN adds o_link_parity (even parity of the completed frame).
module scanner_link_arbiter #(
  parameter int FRAME_BITS = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [1:0] i_req,
  input  logic [1:0] i_scan_clk,
  input  logic [1:0] i_scan_data,
  output logic [1:0] o_ready_out,
  output logic       o_link_clk,
  output logic       o_link_data,
  output logic       o_grant_id,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_timeout_err
`ifdef LINK_PARITY_EN
  ,
  output logic       o_link_parity
`endif
);

  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant_id;
  logic             w_grant_id_nxt;
  logic             r_ptr;
  logic [1:0]       r_scan_clk_d1;
  logic [1:0]       r_scan_clk_d2;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [1:0]       r_ready;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_timeout_err;
  logic             w_edge;
  logic             w_bit_last;
  logic             w_to_exp;
  logic             w_active_nxt;

  // Edge is taken from the two-stage history, so it is seen one cycle after it appears
  assign w_edge       = r_scan_clk_d1[r_grant_id] & ~r_scan_clk_d2[r_grant_id];
  assign w_bit_last   = (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_to_exp     = (r_to_cnt == CNT_W'(TIMEOUT - 1));
  assign w_active_nxt = (w_state_nxt == S_GRANT) || (w_state_nxt == S_XFER);

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (i_req != 2'b00)) begin
          w_state_nxt    = S_GRANT;
          w_grant_id_nxt = (i_req == 2'b11) ? r_ptr : i_req[1];
        end else begin
          w_state_nxt    = S_IDLE;
        end
      end
      S_GRANT: begin
        if (w_edge) begin
          w_state_nxt = w_bit_last ? S_DONE : S_XFER;
        end else if (!i_req[r_grant_id]) begin
          w_state_nxt = S_IDLE;
        end else if (w_to_exp) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      // A final edge arriving together with timeout expiry completes the frame
      S_XFER: begin
        if (w_edge) begin
          w_state_nxt = w_bit_last ? S_DONE : S_XFER;
        end else if (w_to_exp) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_grant_id    <= 1'b0;
      r_ready       <= 2'b00;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_ready       <= w_active_nxt ? (w_grant_id_nxt ? 2'b10 : 2'b01) : 2'b00;
      r_busy        <= w_active_nxt;
      r_frame_done  <= (w_state_nxt == S_DONE);
      r_timeout_err <= (w_state_nxt == S_ABORT);
    end
  end

  // The scanner just served (or stalled) drops to lower priority
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr <= 1'b0;
    end else if ((r_state == S_DONE) || (r_state == S_ABORT)) begin
      r_ptr <= ~r_grant_id;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scan_clk_d1 <= 2'b00;
      r_scan_clk_d2 <= 2'b00;
    end else begin
      r_scan_clk_d1 <= i_scan_clk;
      r_scan_clk_d2 <= r_scan_clk_d1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else if ((r_state == S_GRANT) || (r_state == S_XFER)) begin
      if (w_edge) begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        r_to_cnt  <= '0;
      end else begin
        r_to_cnt  <= r_to_cnt + CNT_W'(1);
      end
    end else begin
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end
  end

  always_comb begin
    o_link_clk  = 1'b0;
    o_link_data = 1'b0;
    if (r_busy) begin
      o_link_clk  = i_scan_clk[r_grant_id];
      o_link_data = i_scan_data[r_grant_id];
    end else begin
      o_link_clk  = 1'b0;
      o_link_data = 1'b0;
    end
  end

  assign o_ready_out   = r_ready;
  assign o_grant_id    = r_grant_id;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_timeout_err = r_timeout_err;

`ifdef LINK_PARITY_EN
  logic [1:0] r_scan_data_d1;
  logic       r_parity;

  // Data is delayed to stay aligned with the delayed clock used for edge detection
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_scan_data_d1 <= 2'b00;
    end else begin
      r_scan_data_d1 <= i_scan_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_parity <= 1'b0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT)) begin
      r_parity <= 1'b0;
    end else if (r_state == S_ABORT) begin
      r_parity <= 1'b0;
    end else if (w_edge && ((r_state == S_GRANT) || (r_state == S_XFER))) begin
      r_parity <= r_parity ^ r_scan_data_d1[r_grant_id];
    end else begin
      r_parity <= r_parity;
    end
  end

  assign o_link_parity = r_parity;
`endif

endmodule
